// File: rtl/out_port_fifo_if.sv
// ============================================================================
// Module   : out_port_fifo_if
// Purpose  : Bus-side and device-side signal bundle for out_port_fifo.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface out_port_fifo_if #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 8,
   parameter int NUM_CH = 4
);
   localparam int c_ch_w  = $clog2(NUM_CH);
   localparam int c_cnt_w = $clog2(DEPTH) + 1;

   logic                OutPortIn;
   logic [WIDTH-1:0]    BusMuxOut;
   logic [c_ch_w-1:0]   ch_sel;
   logic                ovf_clr;
   logic [WIDTH-1:0]    out_data;
   logic [c_ch_w-1:0]   out_ch;
   logic                out_valid;
   logic                out_ready;
   logic [WIDTH-1:0]    last_out;
   logic                full;
   logic                empty;
   logic [c_cnt_w-1:0]  count;
   logic                overflow;

   modport master (
      output OutPortIn, BusMuxOut, ch_sel, ovf_clr, out_ready,
      input  out_data, out_ch, out_valid, last_out, full, empty, count, overflow
   );

   modport slave (
      input  OutPortIn, BusMuxOut, ch_sel, ovf_clr, out_ready,
      output out_data, out_ch, out_valid, last_out, full, empty, count, overflow
   );
endinterface

`default_nettype wire

// File: rtl/out_port_fifo.sv
// ============================================================================
// Module   : out_port_fifo
// Purpose  : Channel-tagged show-ahead output FIFO, or legacy output register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_port_fifo #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 8,
   parameter int NUM_CH = 4,
   parameter int MODE   = 0
) (
   input  wire logic       clock,
   input  wire logic       clear,
   out_port_fifo_if.slave  bus
);
   localparam int c_ch_w   = $clog2(NUM_CH);
   localparam int c_addr_w = $clog2(DEPTH);

   generate
      if (MODE == 0) begin : g_fifo
         localparam logic [c_addr_w:0] c_ptr_one = 1;

         logic [c_addr_w:0]   r_rd_ptr;
         logic [c_addr_w:0]   r_wr_ptr;
         logic [WIDTH-1:0]    r_mem_data [DEPTH];
         logic [c_ch_w-1:0]   r_mem_ch   [DEPTH];
         logic [WIDTH-1:0]    r_last;
         logic                r_ovf;
         logic                w_empty;
         logic                w_full;
         logic                w_pop;
         logic                w_push;
         logic                w_drop;

         // Extra pointer MSB distinguishes full from empty when low bits match.
         assign w_empty = (r_wr_ptr == r_rd_ptr);
         assign w_full  = (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]) &&
                          (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]);
         assign w_pop   = !w_empty && bus.out_ready;
         assign w_push  = bus.OutPortIn && (!w_full || w_pop);
         assign w_drop  = bus.OutPortIn && w_full && !w_pop;

         always_ff @(posedge clock or negedge clear) begin
            if (!clear) begin
               r_rd_ptr <= '0;
               r_wr_ptr <= '0;
               r_last   <= '0;
               r_ovf    <= 1'b0;
               for (int i = 0; i < DEPTH; i++) begin
                  r_mem_data[i] <= '0;
                  r_mem_ch[i]   <= '0;
               end
            end else begin
               if (w_push) begin
                  r_mem_data[r_wr_ptr[c_addr_w-1:0]] <= bus.BusMuxOut;
                  r_mem_ch[r_wr_ptr[c_addr_w-1:0]]   <= bus.ch_sel;
                  r_wr_ptr <= r_wr_ptr + c_ptr_one;
                  r_last   <= bus.BusMuxOut;
               end
               if (w_pop) begin
                  r_rd_ptr <= r_rd_ptr + c_ptr_one;
               end
               // A dropped write outranks a simultaneous clear request.
               if (w_drop) begin
                  r_ovf <= 1'b1;
               end else if (bus.ovf_clr) begin
                  r_ovf <= 1'b0;
               end
            end
         end

         assign bus.out_data  = r_mem_data[r_rd_ptr[c_addr_w-1:0]];
         assign bus.out_ch    = r_mem_ch[r_rd_ptr[c_addr_w-1:0]];
         assign bus.out_valid = !w_empty;
         assign bus.last_out  = r_last;
         assign bus.full      = w_full;
         assign bus.empty     = w_empty;
         assign bus.count     = r_wr_ptr - r_rd_ptr;
         assign bus.overflow  = r_ovf;
      end else begin : g_legacy
         logic [WIDTH-1:0]    r_data;
         logic [c_ch_w-1:0]   r_ch;
         logic                r_valid;
         logic                w_unused;

         // The device side has no back-pressure in this mode.
         assign w_unused = bus.out_ready ^ bus.ovf_clr;

         always_ff @(posedge clock or negedge clear) begin
            if (!clear) begin
               r_data  <= '0;
               r_ch    <= '0;
               r_valid <= 1'b0;
            end else begin
               r_valid <= bus.OutPortIn;
               if (bus.OutPortIn) begin
                  r_data <= bus.BusMuxOut;
                  r_ch   <= bus.ch_sel;
               end
            end
         end

         assign bus.out_data  = r_data;
         assign bus.out_ch    = r_ch;
         assign bus.out_valid = r_valid;
         assign bus.last_out  = r_data;
         assign bus.full      = 1'b0;
         assign bus.empty     = 1'b1;
         assign bus.count     = '0;
         assign bus.overflow  = 1'b0;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_out_port_fifo.sv
// ============================================================================
// Module   : tb_out_port_fifo
// Purpose  : Queue-model bench for out_port_fifo in FIFO and legacy modes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_out_port_fifo;
   localparam int WIDTH  = 32;
   localparam int DEPTH  = 8;
   localparam int NUM_CH = 4;

   logic clock;
   logic clear;

   int n_tests = 0;
   int n_fail  = 0;

   logic [33:0] q[$];
   logic [31:0] m_last;
   logic        m_ovf;

   out_port_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) bus0 ();
   out_port_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) bus1 ();

   out_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .MODE(0)) dut0 (
      .clock (clock),
      .clear (clear),
      .bus   (bus0)
   );

   out_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .MODE(1)) dut1 (
      .clock (clock),
      .clear (clear),
      .bus   (bus1)
   );

   initial clock = 1'b1;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_state();
      check("valid", bus0.out_valid, q.size() != 0);
      check("empty", bus0.empty, q.size() == 0);
      check("full", bus0.full, q.size() == DEPTH);
      check("count", bus0.count, q.size());
      check("cnt_le_depth", bus0.count <= DEPTH, 1);
      check("last_out", bus0.last_out, m_last);
      check("overflow", bus0.overflow, m_ovf);
      if (q.size() != 0) begin
         check("head_data", bus0.out_data, q[0][31:0]);
         check("head_ch", bus0.out_ch, q[0][33:32]);
      end
   endtask

   // One clock of FIFO-mode traffic, with inputs applied just after an edge.
   task automatic cycle(input logic wr, input logic [31:0] d, input logic [1:0] ch,
                        input logic rdy, input logic oc);
      logic        pop;
      logic        push;
      logic [33:0] head;
      bus0.OutPortIn = wr;
      bus0.BusMuxOut = d;
      bus0.ch_sel    = ch;
      bus0.out_ready = rdy;
      bus0.ovf_clr   = oc;
      pop  = (q.size() != 0) && rdy;
      push = wr && ((q.size() < DEPTH) || pop);
      if (pop) begin
         head = q.pop_front();
         check("pop_data", bus0.out_data, head[31:0]);
         check("pop_ch", bus0.out_ch, head[33:32]);
      end
      if (push) begin
         q.push_back({ch, d});
         m_last = d;
      end
      if (wr && !push) m_ovf = 1'b1;
      else if (oc) m_ovf = 1'b0;
      @(posedge clock);
      #1;
      check_state();
   endtask

   initial begin
      logic [31:0] v;
      logic [31:0] l_data;
      logic [1:0]  l_ch;
      logic        l_wr;
      clear = 1'b0;
      m_last = '0;
      m_ovf  = 1'b0;
      bus0.OutPortIn = 0; bus0.BusMuxOut = '0; bus0.ch_sel = '0; bus0.ovf_clr = 0; bus0.out_ready = 0;
      bus1.OutPortIn = 0; bus1.BusMuxOut = '0; bus1.ch_sel = '0; bus1.ovf_clr = 0; bus1.out_ready = 0;

      #12;
      check("rst_valid", bus0.out_valid, 0);
      check("rst_empty", bus0.empty, 1);
      check("rst_count", bus0.count, 0);
      check("rst_last", bus0.last_out, 0);
      check("rst_ovf", bus0.overflow, 0);
      check("rst_data", bus0.out_data, 0);
      check("rst1_valid", bus1.out_valid, 0);
      check("rst1_data", bus1.out_data, 0);
      #3 clear = 1'b1;
      @(posedge clock);
      #1;
      check_state();

      // Three tagged words, then drain.
      cycle(1, 32'h11, 2'd0, 0, 0);
      cycle(1, 32'h22, 2'd1, 0, 0);
      cycle(1, 32'h33, 2'd3, 0, 0);
      check("three_count", bus0.count, 3);
      for (int i = 0; i < 3; i++) cycle(0, '0, '0, 1, 0);
      check("drained_empty", bus0.empty, 1);

      // Fill, overflow, clear overflow.
      for (int i = 0; i < 8; i++) cycle(1, 32'hA0 + i, i[1:0], 0, 0);
      cycle(1, 32'hFF, 2'd2, 0, 0);
      check("ovf_set", bus0.overflow, 1);
      check("ovf_last", bus0.last_out, 32'hA7);
      cycle(0, '0, '0, 0, 1);
      check("ovf_clr", bus0.overflow, 0);

      // Push and pop together while full.
      cycle(1, 32'hB0, 2'd1, 1, 0);
      check("full_pp_count", bus0.count, 8);
      for (int i = 0; i < 8; i++) cycle(0, '0, '0, 1, 0);

      // Drop and clear in the same edge: set must win.
      for (int i = 0; i < 8; i++) cycle(1, 32'hC0 + i, 2'd0, 0, 0);
      cycle(1, 32'hEE, 2'd0, 0, 1);
      check("ovf_set_wins", bus0.overflow, 1);
      for (int i = 0; i < 8; i++) cycle(0, '0, '0, 1, 1);

      // Wrap: incrementing values with random stalls.
      v = 32'h100;
      for (int i = 0; i < 60 && v < 32'h114; i++) begin
         l_wr = (q.size() < DEPTH);
         cycle(l_wr, v, v[1:0], 1'($urandom_range(0, 1)), 0);
         if (l_wr) v = v + 1;
      end
      for (int i = 0; i < 10; i++) cycle(0, '0, '0, 1, 0);

      // Fully random traffic.
      for (int i = 0; i < 300; i++) begin
         cycle(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 3) != 0 ? 1 : 0) & 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 7) == 0));
      end

      // Asynchronous reset with entries queued.
      for (int i = 0; i < 5; i++) cycle(1, 32'h50 + i, 2'd2, 0, 0);
      clear = 1'b0;
      #2;
      check("mid_rst_valid", bus0.out_valid, 0);
      check("mid_rst_count", bus0.count, 0);
      check("mid_rst_empty", bus0.empty, 1);
      check("mid_rst_last", bus0.last_out, 0);
      check("mid_rst_data", bus0.out_data, 0);
      q.delete();
      m_last = '0;
      m_ovf  = 1'b0;
      bus0.OutPortIn = 0; bus0.out_ready = 0; bus0.ovf_clr = 0;
      #3 clear = 1'b1;
      @(posedge clock);
      #1;
      check_state();
      for (int i = 0; i < 20; i++)
         cycle(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);

      // Legacy register mode.
      bus1.OutPortIn = 1; bus1.BusMuxOut = 32'h1234; bus1.ch_sel = 2'd2; bus1.out_ready = 0;
      @(posedge clock);
      #1;
      bus1.OutPortIn = 0;
      check("leg_data", bus1.out_data, 32'h1234);
      check("leg_ch", bus1.out_ch, 2);
      check("leg_valid", bus1.out_valid, 1);
      check("leg_last", bus1.last_out, 32'h1234);
      check("leg_full", bus1.full, 0);
      check("leg_empty", bus1.empty, 1);
      check("leg_count", bus1.count, 0);
      @(posedge clock);
      #1;
      check("leg_pulse_end", bus1.out_valid, 0);
      check("leg_hold", bus1.out_data, 32'h1234);
      l_data = 32'h1234;
      l_ch   = 2'd2;
      for (int i = 0; i < 40; i++) begin
         l_wr = 1'($urandom_range(0, 1));
         bus1.OutPortIn = l_wr;
         bus1.BusMuxOut = $urandom;
         bus1.ch_sel    = 2'($urandom_range(0, 3));
         bus1.out_ready = 1'($urandom_range(0, 1));
         bus1.ovf_clr   = 1'($urandom_range(0, 1));
         if (l_wr) begin
            l_data = bus1.BusMuxOut;
            l_ch   = bus1.ch_sel;
         end
         @(posedge clock);
         #1;
         check("leg_r_valid", bus1.out_valid, l_wr);
         check("leg_r_data", bus1.out_data, l_data);
         check("leg_r_ch", bus1.out_ch, l_ch);
         check("leg_r_last", bus1.last_out, l_data);
         check("leg_r_ovf", bus1.overflow, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
